// File: rtl/spi_sample_transmitter.sv
// SPI mode-0 controller: shifts buffered DATA_W-bit samples out on MOSI (MSB first)
// while capturing the peripheral's MISO word in the same frame.
module spi_sample_transmitter #(
  parameter int DATA_W      = 16,
  parameter int HALF_PERIOD = 2,
  parameter int CS_IDLE     = 2
) (
  input  logic              input_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int CMAX = (HALF_PERIOD > CS_IDLE) ? HALF_PERIOD : CS_IDLE;
  localparam int CW   = $clog2(CMAX) + 1;
  // Bit counter must reach DATA_W itself, hence the extra bit.
  localparam int BW   = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bitcnt;
  logic [DATA_W-1:0] r_buf;
  logic              r_buf_full;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_rxsh;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_sclk;
  logic              r_cs_n;
  logic              r_mosi;

  logic w_hp_done;
  logic w_gap_done;
  logic w_last_bit;

  assign w_hp_done  = (r_cnt == CW'(HALF_PERIOD - 1));
  assign w_gap_done = (r_cnt == CW'(CS_IDLE - 1));
  assign w_last_bit = (r_bitcnt == BW'(DATA_W));

  assign tx_ready = !r_buf_full;
  assign busy     = (r_state != S_IDLE) || r_buf_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign spi_sclk = r_sclk;
  assign spi_cs_n = r_cs_n;
  assign spi_mosi = r_mosi;

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bitcnt   <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_shreg    <= '0;
      r_rxsh     <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (tx_valid && !r_buf_full) begin
        r_buf      <= tx_data;
        r_buf_full <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (r_buf_full) begin
            r_shreg    <= r_buf;
            r_mosi     <= r_buf[DATA_W-1];
            r_cs_n     <= 1'b0;
            r_buf_full <= 1'b0;
            r_state    <= S_LEAD;
          end
        end
        // End of the setup half period doubles as the first rising edge.
        S_LEAD: begin
          if (w_hp_done) begin
            r_cnt    <= '0;
            r_sclk   <= 1'b1;
            r_rxsh   <= {r_rxsh[DATA_W-2:0], spi_miso};
            r_bitcnt <= BW'(1);
            r_state  <= S_SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_hp_done) begin
            r_cnt <= '0;
            if (r_sclk) begin
              r_sclk <= 1'b0;
              if (!w_last_bit) begin
                r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
                r_mosi  <= r_shreg[DATA_W-2];
              end
            end else if (w_last_bit) begin
              r_state <= S_TRAIL;
            end else begin
              r_sclk   <= 1'b1;
              r_rxsh   <= {r_rxsh[DATA_W-2:0], spi_miso};
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_TRAIL: begin
          if (w_hp_done) begin
            r_cnt      <= '0;
            r_cs_n     <= 1'b1;
            r_rx_data  <= r_rxsh;
            r_rx_valid <= 1'b1;
            r_state    <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (w_gap_done) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
